md_unit: RTL

Multiply/divide unit with the HI/LO register pair, instantiated in the Execute stage of the five-stage pipeline. It accepts mult/multu/div/divu, runs a fixed-latency busy window, then commits results to HI/LO. It services mthi/mtlo/mfhi/mflo and drives `HILObusy`, which the stall unit uses to hold md/mt/mf instructions in Decode.

---
 rtl/md_unit_pkg.sv | 40 ++++
 rtl/md_unit_if.sv | 24 ++
 rtl/md_unit_calc.sv | 69 ++++++
 rtl/md_unit.sv | 84 ++++++++
 4 files changed

// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// FSM states, default latencies and small decode helpers.
package md_unit_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  function automatic logic is_md_op(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div_op(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Counter must hold the longest latency and is never narrower than 4 bits.
  function automatic int cnt_width(input int max_cycles);
    int w;
    w = $clog2(max_cycles + 1);
    return (w < 4) ? 4 : w;
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// Execute-stage <-> multiply/divide unit bundle: request fields in,
// read data and busy indications out.
interface md_unit_if;
  import md_unit_pkg::*;

  logic        start;
  md_op_e      MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] MDOut;
  logic        busy;
  logic        HILObusy;

  modport master (
    output start, MDOp, A, B,
    input  MDOut, busy, HILObusy
  );

  modport slave (
    input  start, MDOp, A, B,
    output MDOut, busy, HILObusy
  );

endinterface

// File: rtl/md_unit_calc.sv
// Combinational multiply/divide datapath (md_calc): produces HI/LO results
// and a write enable that is low for division by zero.
module md_unit_calc
  import md_unit_pkg::*;
(
  input  md_op_e      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res,
  output logic        wr_en
);

  logic signed [63:0] a_sx, b_sx, prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] b_safe_u, quot_u, rem_u;
  logic        [31:0] a_mag, b_mag, b_safe_s, q_mag, r_mag, quot_s, rem_s;

  assign a_sx   = {{32{a[31]}}, a};
  assign b_sx   = {{32{b[31]}}, b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Divisors are forced to 1 on zero so the dividers never see 0; the
  // result is then dropped through wr_en.
  assign b_safe_u = (b == 32'd0) ? 32'd1 : b;
  assign quot_u   = a / b_safe_u;
  assign rem_u    = a % b_safe_u;

  // Signed division on magnitudes avoids the INT_MIN / -1 overflow case;
  // 0x80000000 negated stays 0x80000000 which is the required quotient.
  assign a_mag    = a[31] ? (~a + 32'd1) : a;
  assign b_mag    = b[31] ? (~b + 32'd1) : b;
  assign b_safe_s = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign q_mag    = a_mag / b_safe_s;
  assign r_mag    = a_mag % b_safe_s;
  assign quot_s   = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
  assign rem_s    = a[31] ? (~r_mag + 32'd1) : r_mag;

  always_comb begin
    hi_res = '0;
    lo_res = '0;
    wr_en  = 1'b0;
    case (op)
      MD_MULT: begin
        hi_res = prod_s[63:32];
        lo_res = prod_s[31:0];
        wr_en  = 1'b1;
      end
      MD_MULTU: begin
        hi_res = prod_u[63:32];
        lo_res = prod_u[31:0];
        wr_en  = 1'b1;
      end
      MD_DIV: begin
        hi_res = rem_s;
        lo_res = quot_s;
        wr_en  = (b != 32'd0);
      end
      MD_DIVU: begin
        hi_res = rem_u;
        lo_res = quot_u;
        wr_en  = (b != 32'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO pair: fixed-latency busy window after a
// start, commit at the end of the window, mthi/mtlo/mfhi/mflo servicing.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input logic       clk,
  input logic       reset,
  md_unit_if.slave  bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = cnt_width(MAX_CYCLES);

  md_state_e          state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               busy_reg;
  logic               commit_reg;
  logic [31:0]        hi_reg, lo_reg, hi_tmp_reg, lo_tmp_reg;
  logic [31:0]        hi_res, lo_res;
  logic               wr_en;

  md_unit_calc u_calc (
    .op     (bus.MDOp),
    .a      (bus.A),
    .b      (bus.B),
    .hi_res (hi_res),
    .lo_res (lo_res),
    .wr_en  (wr_en)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
      commit_reg <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      hi_tmp_reg <= '0;
      lo_tmp_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          // start wins over an mthi/mtlo encoding presented in the same cycle
          if (bus.start) begin
            if (is_md_op(bus.MDOp)) begin
              hi_tmp_reg <= hi_res;
              lo_tmp_reg <= lo_res;
              commit_reg <= wr_en;
              cnt_reg    <= is_div_op(bus.MDOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
              busy_reg   <= 1'b1;
              state_reg  <= ST_BUSY;
            end
          end else if (bus.MDOp == MD_MTHI) begin
            hi_reg <= bus.A;
          end else if (bus.MDOp == MD_MTLO) begin
            lo_reg <= bus.A;
          end
        end
        ST_BUSY: begin
          cnt_reg <= cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) begin
            if (commit_reg) begin
              hi_reg <= hi_tmp_reg;
              lo_reg <= lo_tmp_reg;
            end
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_reg;
  assign bus.HILObusy = bus.start | busy_reg;
  assign bus.MDOut    = (bus.MDOp == MD_MFHI) ? hi_reg :
                        (bus.MDOp == MD_MFLO) ? lo_reg : 32'd0;

endmodule
